// File: rtl/mult_fu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mult_fu_pipe
//  Description : Pipelined RV32M integer multiplier (MUL/MULH/MULHSU/MULHU).
//                It presents a done/rob_tag/result slot to the CDB arbiter
//                and holds it until the arbiter acks. While a completed
//                result is waiting for its ack, the whole pipeline stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_fu_pipe #(
  parameter int XLEN      = 32,
  parameter int STAGES    = 4,   // issue-to-done latency, legal 1..8
  parameter int ROB_TAG_W = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [1:0]           in_func,
  input  logic [XLEN-1:0]      in_rs1,
  input  logic [XLEN-1:0]      in_rs2,
  input  logic [ROB_TAG_W-1:0] in_rob_tag,
  output logic                 ready,
  output logic                 done,
  output logic [ROB_TAG_W-1:0] out_rob_tag,
  output logic [XLEN-1:0]      out_v,
  input  logic                 ack
);

  localparam int c_pw   = 2 * XLEN;                    // full product width
  localparam int c_cw   = (c_pw + STAGES - 1) / STAGES; // multiplier bits per stage
  localparam int c_last = STAGES - 1;
  localparam logic [c_pw-1:0] c_mask = (c_pw'(1) << c_cw) - c_pw'(1);

  localparam logic [1:0] c_func_mul    = 2'd0;
  localparam logic [1:0] c_func_mulh   = 2'd1;
  localparam logic [1:0] c_func_mulhu  = 2'd3;

  // Per-stage state. a/b carry the extended operands, acc the running sum.
  logic [STAGES-1:0]    valid_q;
  logic [ROB_TAG_W-1:0] tag_q  [STAGES];
  logic [1:0]           func_q [STAGES];
  logic [c_pw-1:0]      a_q    [STAGES];
  logic [c_pw-1:0]      b_q    [STAGES];
  logic [c_pw-1:0]      acc_q  [STAGES];
  logic [c_pw-1:0]      acc_d  [STAGES];

  logic                 w_stall;
  logic                 w_accept;
  logic                 w_rs1_signed;
  logic                 w_rs2_signed;
  logic [c_pw-1:0]      w_a_ext;
  logic [c_pw-1:0]      w_b_ext;
  logic [c_pw-1:0]      w_a_in [STAGES];
  logic [c_pw-1:0]      w_b_in [STAGES];
  logic [c_pw-1:0]      w_pp   [STAGES];

  // A waiting result blocks the pipe; ready and issue acceptance follow from it.
  always_comb begin
    w_stall  = done & ~ack;
    ready    = ~w_stall;
    w_accept = in_valid & ready & ~clear;
  end

  // Extend operands to 2*XLEN. Keeping the product modulo 2^(2*XLEN) with
  // both operands extended gives the exact signed/unsigned product bits.
  always_comb begin
    w_rs1_signed = (in_func != c_func_mulhu);
    w_rs2_signed = (in_func == c_func_mul) || (in_func == c_func_mulh);
    w_a_ext      = {{XLEN{w_rs1_signed & in_rs1[XLEN-1]}}, in_rs1};
    w_b_ext      = {{XLEN{w_rs2_signed & in_rs2[XLEN-1]}}, in_rs2};
  end

  // Stage k adds the partial product of A with the k-th unsigned slice of B.
  always_comb begin
    w_a_in[0] = w_a_ext;
    w_b_in[0] = w_b_ext;
    for (int k = 1; k < STAGES; k++) begin
      w_a_in[k] = a_q[k-1];
      w_b_in[k] = b_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_pp[k] = (w_a_in[k] * ((w_b_in[k] >> (k * c_cw)) & c_mask)) << (k * c_cw);
    end
    acc_d[0] = w_pp[0];
    for (int k = 1; k < STAGES; k++) begin
      acc_d[k] = acc_q[k-1] + w_pp[k];
    end
  end

  // Valid bits: squashed by reset/clear, otherwise shift unless stalled.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid_q <= '0;
    end else if (!w_stall) begin
      valid_q[0] <= w_accept;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  // Payload registers advance in lock-step with the valid bits; never reset,
  // because outputs are gated by done.
  always_ff @(posedge clock) begin
    if (!w_stall) begin
      tag_q[0]  <= in_rob_tag;
      func_q[0] <= in_func;
      a_q[0]    <= w_a_ext;
      b_q[0]    <= w_b_ext;
      acc_q[0]  <= acc_d[0];
      for (int k = 1; k < STAGES; k++) begin
        tag_q[k]  <= tag_q[k-1];
        func_q[k] <= func_q[k-1];
        a_q[k]    <= a_q[k-1];
        b_q[k]    <= b_q[k-1];
        acc_q[k]  <= acc_d[k];
      end
    end
  end

  // Present the last stage; tag and value read zero when nothing is done.
  always_comb begin
    done        = valid_q[c_last];
    out_rob_tag = '0;
    out_v       = '0;
    if (done) begin
      out_rob_tag = tag_q[c_last];
      out_v       = (func_q[c_last] == c_func_mul) ? acc_q[c_last][XLEN-1:0]
                                                   : acc_q[c_last][c_pw-1:XLEN];
    end
  end

  // The arbiter must only grant a slot that is actually presenting a result.
  a_ack_needs_done: assert property (@(posedge clock) disable iff (reset) ack |-> done);

endmodule
`default_nettype wire

// File: tb/tb_mult_fu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_fu_pipe
//  Description : Directed self-checking bench for mult_fu_pipe (STAGES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_fu_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [1:0]  in_func;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rob_tag;
  logic        ready;
  logic        done;
  logic [4:0]  out_rob_tag;
  logic [31:0] out_v;
  logic        ack;
  logic        ack_en;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [1:0]  vf   [8];
  logic [31:0] va   [8];
  logic [31:0] vb   [8];
  logic [31:0] vexp [8];

  // The CDB grants combinationally from done, gated by the bench.
  assign ack = ack_en & done;

  always #5 clock = ~clock;

  mult_fu_pipe #(.XLEN(32), .STAGES(4), .ROB_TAG_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_func    (in_func),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rob_tag (in_rob_tag),
    .ready      (ready),
    .done       (done),
    .out_rob_tag(out_rob_tag),
    .out_v      (out_v),
    .ack        (ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    in_valid   = 1'b1;
    in_func    = f;
    in_rs1     = a;
    in_rs2     = b;
    in_rob_tag = t;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_func    = 2'd0;
    in_rs1     = 32'd0;
    in_rs2     = 32'd0;
    in_rob_tag = 5'd0;
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  // Compare the presented slot against an expectation (zeros when idle).
  task automatic chk_slot(input string tag, input logic exp_done,
                          input logic [4:0] exp_tag, input logic [31:0] exp_v);
    chk({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, ".tag"},  {27'd0, out_rob_tag}, exp_done ? {27'd0, exp_tag} : 32'd0);
    chk({tag, ".v"},    out_v, exp_done ? exp_v : 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    clear  = 1'b0;
    ack_en = 1'b1;
    idle();
    adv();
    adv();
    reset = 1'b0;
    #1;
    chk_slot("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.ready", {31'd0, ready}, 32'd1);
    adv();

    // Single MUL 7 * -3 = -21, done only in cycle 4.
    for (int c = 0; c < 6; c++) begin
      if (c == 0) issue(2'd0, 32'd7, 32'hFFFF_FFFD, 5'd5); else idle();
      #1;
      chk_slot("single", (c == 4), 5'd5, 32'hFFFF_FFEB);
      chk("single.ready", {31'd0, ready}, 32'd1);
      adv();
    end

    // Back-to-back: op i = (i+1)*(i+2) with tag 10+i, done cycles 4..9.
    for (int c = 0; c < 11; c++) begin
      if (c < 6) issue(2'd0, 32'(c + 1), 32'(c + 2), 5'(10 + c)); else idle();
      #1;
      chk_slot("b2b", (c >= 4 && c <= 9), 5'(10 + c - 4), 32'((c - 3) * (c - 2)));
      chk("b2b.ready", {31'd0, ready}, 32'd1);
      adv();
    end

    // Stall: ops (100+i)*3, tags 20..22; ack withheld cycles 4..7.
    for (int c = 0; c < 12; c++) begin
      if (c < 3) issue(2'd0, 32'(100 + c), 32'd3, 5'(20 + c)); else idle();
      ack_en = !(c >= 4 && c <= 7);
      #1;
      if (c <= 8) chk_slot("stall", (c >= 4), 5'd20, 32'd300);
      else        chk_slot("stall", (c <= 10), 5'(21 + c - 9), 32'(303 + 3 * (c - 9)));
      chk("stall.ready", {31'd0, ready}, (c >= 4 && c <= 7) ? 32'd0 : 32'd1);
      adv();
    end
    ack_en = 1'b1;

    // Function corner cases, tags 16..23, done cycles 4..11.
    vf[0] = 2'd1; va[0] = 32'h8000_0000; vb[0] = 32'h8000_0000; vexp[0] = 32'h4000_0000;
    vf[1] = 2'd2; va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; vexp[1] = 32'hFFFF_FFFF;
    vf[2] = 2'd3; va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; vexp[2] = 32'hFFFF_FFFE;
    vf[3] = 2'd0; va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; vexp[3] = 32'h0000_0001;
    vf[4] = 2'd1; va[4] = 32'd7;         vb[4] = 32'hFFFF_FFFD; vexp[4] = 32'hFFFF_FFFF;
    vf[5] = 2'd3; va[5] = 32'h8000_0000; vb[5] = 32'd2;         vexp[5] = 32'h0000_0001;
    vf[6] = 2'd2; va[6] = 32'h8000_0000; vb[6] = 32'h8000_0000; vexp[6] = 32'hC000_0000;
    vf[7] = 2'd0; va[7] = 32'h1234_5678; vb[7] = 32'h0000_0010; vexp[7] = 32'h2345_6780;
    for (int c = 0; c < 13; c++) begin
      if (c < 8) issue(vf[c], va[c], vb[c], 5'(16 + c)); else idle();
      #1;
      if (c >= 4 && c <= 11) chk_slot("func", 1'b1, 5'(16 + c - 4), vexp[c - 4]);
      else                   chk_slot("func", 1'b0, 5'd0, 32'd0);
      adv();
    end

    // Clear in cycle 2 squashes ops 0..2; op 3 (5*6, tag 4) completes in cycle 7.
    for (int c = 0; c < 9; c++) begin
      if (c < 4) issue(2'd0, 32'(c + 2), 32'(c + 3), 5'(c + 1)); else idle();
      clear = (c == 2);
      #1;
      chk_slot("clear", (c == 7), 5'd4, 32'd30);
      adv();
    end
    clear = 1'b0;

    // Reset while stalled: 3*4 tag 9 held cycles 4..5, reset in cycle 5.
    ack_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) issue(2'd0, 32'd3, 32'd4, 5'd9); else idle();
      reset = (c == 5);
      #1;
      chk_slot("rststall", (c == 4 || c == 5), 5'd9, 32'd12);
      chk("rststall.ready", {31'd0, ready}, (c == 4 || c == 5) ? 32'd0 : 32'd1);
      adv();
    end
    reset  = 1'b0;
    ack_en = 1'b1;

    // Clear coinciding with done&ack: result is not re-presented.
    for (int c = 0; c < 7; c++) begin
      if (c == 0) issue(2'd3, 32'hFFFF_FFFF, 32'd2, 5'd3); else idle();
      clear = (c == 4);
      #1;
      chk_slot("clrack", (c == 4), 5'd3, 32'd1);
      adv();
    end
    clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
